// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, frame geometry and default bit timing.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int DATA_BITS            = 8;
    localparam int STORED_BITS          = 7;
    localparam int DEFAULT_CLKS_PER_BIT = 217;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver signal bundle: serial line and ack in, character plus sticky status out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                   rx;
    logic                   ack;
    logic [STORED_BITS-1:0] data;
    logic                   avail;
    logic                   overrun;
    logic                   frame_err;

    modport slave  (input rx, ack, output data, avail, overrun, frame_err);
    modport master (output rx, ack, input data, avail, overrun, frame_err);

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff_q <= {2{RST_VAL}};
        else       ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver keeping the low 7 data bits; UART_RX_MAJORITY_EN enables 2-of-3 sampling.
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // Decisions land one cycle after the nominal sample point so its successor is available.
    localparam logic [15:0] START_CNT = 16'(CLKS_PER_BIT / 2 + 1);
`else
    localparam logic [15:0] START_CNT = 16'(CLKS_PER_BIT / 2);
`endif

    uart_state_e            state_q;
    logic [15:0]            cnt_q;
    logic [2:0]             idx_q;
    logic [STORED_BITS-1:0] shift_q;
    logic [STORED_BITS-1:0] data_q;
    logic                   avail_q;
    logic                   overrun_q;
    logic                   frame_err_q;
    logic                   rx_s;
    logic                   smp_d;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= 2'b11;
        else       hist_q <= {hist_q[0], rx_s};
    end

    assign smp_d = maj3(rx_s, hist_q[0], hist_q[1]);
`else
    assign smp_d = rx_s;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            avail_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // Status clears first so a same-cycle frame event below overrides it.
            if (bus.ack) begin
                avail_q     <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            cnt_q <= cnt_q + 16'd1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s) state_q <= START;
                end
                START: begin
                    if (cnt_q == START_CNT) begin
                        cnt_q   <= '0;
                        state_q <= smp_d ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q < 3'(STORED_BITS)) shift_q[idx_q] <= smp_d;
                        if (idx_q == 3'(DATA_BITS - 1)) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!smp_d) begin
                            frame_err_q <= 1'b1;
                        end else if (avail_q && !bus.ack) begin
                            overrun_q <= 1'b1;
                        end else begin
                            data_q  <= shift_q;
                            avail_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.avail     = avail_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed scenarios then random frames against a
// frame-level model of the character/status registers.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    // rx is driven just after an edge; two sync flops plus the IDLE cycle put the
    // nominal sample of bit k at rx cycle CPB/2+1+CPB*k.
    localparam int SMP0 = CPB / 2 + 1;
    localparam int RISE = SMP0 + 9 * CPB + 3 + (MAJ ? 1 : 0);

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] data_m;
    logic       avail_m, ovr_m, ferr_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"},  32'(bus.data),      32'(data_m));
        chk({tag, "_avail"}, 32'(bus.avail),     32'(avail_m));
        chk({tag, "_ovr"},   32'(bus.overrun),   32'(ovr_m));
        chk({tag, "_ferr"},  32'(bus.frame_err), 32'(ferr_m));
    endtask

    task automatic model_reset();
        data_m = '0; avail_m = 1'b0; ovr_m = 1'b0; ferr_m = 1'b0;
    endtask

    // A frame's effect on the visible registers, with optional ack landing on its stop decision.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_at_stop,
                               input logic [7:0] gmask);
        logic [7:0] rb;
        rb = MAJ ? b : (b ^ gmask);
        if (ack_at_stop) begin
            avail_m = 1'b0; ovr_m = 1'b0; ferr_m = 1'b0;
        end
        if (!stop_ok)     ferr_m = 1'b1;
        else if (avail_m) ovr_m  = 1'b1;
        else begin
            data_m  = rb[6:0];
            avail_m = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bus.rx  = 1'b1;
        bus.ack = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        avail_m = 1'b0; ovr_m = 1'b0; ferr_m = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic [7:0] gmask,
                              input int ack_at, input int abort_at, output int rise_at);
        logic [9:0] bits;
        logic       lv;
        logic       was_avail;
        bits      = {stop_bit, b, 1'b0};
        was_avail = bus.avail;
        rise_at   = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (i == abort_at) return;
            lv = bits[4'(i / CPB)];
            for (int j = 0; j < 8; j++)
                if (gmask[3'(j)] && i == SMP0 + CPB * (j + 1)) lv = ~lv;
            bus.rx  = lv;
            bus.ack = (i == ack_at);
            @(posedge clk); #1;
            if (rise_at < 0 && !was_avail && bus.avail) rise_at = i + 1;
        end
        bus.rx  = 1'b1;
        bus.ack = 1'b0;
    endtask

    initial begin
        int         rise;
        logic [7:0] rb;
        logic       rstop;
        logic [7:0] rmask;

        bus.rx  = 1'b1;
        bus.ack = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        chk("reset_cnt",   32'(dut.cnt_q),   32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(5);

        // Clean character, with the exact cycle avail rises.
        send_frame(8'h41, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h41, 1'b1, 1'b0, 8'h00);
        chk("t41_rise", 32'(rise), 32'(RISE));
        idle(20);
        check_all("t41");
        pulse_ack();
        check_all("t41_ack");

        // Short low pulse is a false start.
        bus.rx = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        idle(30);
        chk("false_state", 32'(dut.state_q), 32'(IDLE));
        check_all("false");

        send_frame(8'h55, 1'b0, 8'h00, -1, -1, rise);
        model_frame(8'h55, 1'b0, 1'b0, 8'h00);
        idle(20);
        check_all("ferr");
        pulse_ack();
        check_all("ferr_ack");

        send_frame(8'h12, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h12, 1'b1, 1'b0, 8'h00);
        idle(12);
        send_frame(8'h34, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h34, 1'b1, 1'b0, 8'h00);
        idle(20);
        check_all("ovr");
        pulse_ack();
        check_all("ovr_ack");

        // ack on the stop-decision cycle while avail=1: the new frame loads.
        send_frame(8'h11, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h11, 1'b1, 1'b0, 8'h00);
        idle(12);
        send_frame(8'h66, 1'b1, 8'h00, RISE - 1, -1, rise);
        model_frame(8'h66, 1'b1, 1'b1, 8'h00);
        idle(20);
        check_all("ackset");
        pulse_ack();

        // Reset mid-frame with rx already low; the low after release is a fresh start bit.
        send_frame(8'h33, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h33, 1'b1, 1'b0, 8'h00);
        idle(12);
        send_frame(8'h6C, 1'b1, 8'h00, -1, SMP0 + CPB * 5, rise);
        bus.rx = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_frame(8'h7F, 1'b1, 8'h00, -1, -1, rise);
        model_frame(8'h7F, 1'b1, 1'b0, 8'h00);
        chk("t7F_rise", 32'(rise), 32'(RISE));
        idle(20);
        check_all("t7F");
        pulse_ack();

        send_frame(8'h2A, 1'b1, 8'hFF, -1, -1, rise);
        model_frame(8'h2A, 1'b1, 1'b0, 8'hFF);
        idle(20);
        check_all("glitch");

        for (int n = 0; n < 24; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rmask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 1) == 1) pulse_ack();
            send_frame(rb, rstop, rmask, -1, -1, rise);
            model_frame(rb, rstop, 1'b0, rmask);
            idle(12 + $urandom_range(0, 8));
            check_all($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217: clocks per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port ack, input, 1: consumer has taken data; clears avail, overrun and frame_err.
REQ-006 SHALL have port data, output, 7: last accepted character.
REQ-007 SHALL have port avail, output, 1: data holds an unread character.
REQ-008 SHALL have port overrun, output, 1: sticky; a complete frame was dropped because avail was high.
REQ-009 SHALL have port frame_err, output, 1: sticky; a frame ended with stop bit low.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 SHALL decode frames of 10 bit-times: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
REQ-012 SHALL store data bits 0..6 into data[6:0] and SHALL ignore the value of data bit 7.
REQ-013 SHALL implement the states IDLE, START, DATA and STOP with a 16-bit bit-time counter and a 3-bit bit index.
REQ-014 IDLE -> START SHALL occur on the first synchronized low; the counter SHALL clear.
REQ-015 START SHALL sample at count CLKS_PER_BIT/2 (integer divide): low -> DATA with the counter cleared; high -> IDLE (false start, no flags).
REQ-016 DATA SHALL sample each bit at count CLKS_PER_BIT-1 after the previous sample point, i.e. at mid-bit; after the 8th sample it SHALL go to STOP.
REQ-017 STOP SHALL sample at mid stop bit and SHALL then return to IDLE in the next cycle, so a start bit immediately following is accepted.
REQ-018 Stop sample high with avail=0: data SHALL load and avail SHALL assert on the cycle after the stop sample.
REQ-019 Stop sample high with avail=1: data and avail SHALL be unchanged, and overrun SHALL set.
REQ-020 Stop sample low: data and avail SHALL be unchanged, and frame_err SHALL set.
REQ-021 A cycle with ack=1 SHALL clear avail, overrun and frame_err on the next edge.
REQ-022 If ack and a set event coincide, the set SHALL win; a frame completing in the same cycle as ack while avail=1 SHALL load as if avail were 0.
REQ-023 data SHALL be stable whenever avail=1.

Reset
REQ-024 reset SHALL force state IDLE, counter 0, bit index 0, both synchronizer flops 1, data 0, avail 0, overrun 0 and frame_err 0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, a low already present on rx SHALL be treated as a new start edge.

Configuration
REQ-026 With macro UART_RX_MAJORITY_EN defined, each sample SHALL be the 2-of-3 majority of the synchronized rx at sample point-1, sample point and sample point+1; the state transition SHALL occur at sample point+1.
REQ-027 Without UART_RX_MAJORITY_EN, each sample SHALL be the single synchronized value at the sample point.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enumeration (IDLE, START, DATA, STOP), the frame constants (DATA_BITS=8, STORED_BITS=7) and the default CLKS_PER_BIT=217, shared with the transmitter.
REQ-029 The synchronizer SHALL be a separate sub-module sync2 (two flops, parameterizable reset value); everything else SHALL stay in uart_rx.

Verification (bench uses CLKS_PER_BIT=16)
REQ-030 Send 0x41 at exact baud -> data=7'h41 and avail=1 one cycle after the stop sample; overrun=0 and frame_err=0.
REQ-031 Drive rx low for 3 cycles then high -> no avail, state back to IDLE, no flags set.
REQ-032 Send 0x55 with the stop bit forced low -> frame_err=1, avail=0; then ack=1 -> frame_err=0.
REQ-033 Send 0x12 then 0x34 with no ack -> data=7'h12, avail=1, overrun=1; then ack=1 -> all three flags cleared.
REQ-034 Assert reset at bit 4 of a frame, then send 0x7F -> data=7'h7F with no corruption from the aborted frame.
REQ-035 With UART_RX_MAJORITY_EN defined, inject a 1-cycle glitch at each data-bit sample point of 0x2A -> data=7'h2A; without the macro, the glitched bit flips.
